// File: rtl/byte_memory_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_memory_write_arbiter_pkg
// Purpose  : shared FSM encoding and requester ids for the write arbiter
// Revision : 1.0  initial release
// ============================================================================
package byte_memory_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic other_req(input logic id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_memory_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : byte_memory_write_arbiter_rr_arbiter2
// Purpose  : two-way combinational round-robin pick; prio names the winner on a tie
// Revision : 1.0  initial release
// ============================================================================
module byte_memory_write_arbiter_rr_arbiter2
  import byte_memory_write_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  input  logic en,
  output logic grant_id,
  output logic grant_valid
);

  always_comb begin
    grant_valid = en & (req0 | req1);
    grant_id    = REQ0;
    if (req0 && req1) begin
      grant_id = prio;
    end else if (req1) begin
      grant_id = REQ1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/byte_memory_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : byte_memory_write_arbiter
// Purpose  : round-robin write sequencer driving a latch-based byte memory bank
// Revision : 1.0  initial release
// ============================================================================
module byte_memory_write_arbiter
  import byte_memory_write_arbiter_pkg::*;
#(
  parameter int BIT_COUNT  = 8,
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [BIT_COUNT-1:0]  data0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BIT_COUNT-1:0]  data1,
  output logic                  ack1,
  output logic [BIT_COUNT-1:0]  mem_data,
  output logic [NUM_WORDS-1:0]  mem_store,
  output logic                  err,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic                  id_q, id_d;
  logic                  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BIT_COUNT-1:0]  mem_data_q, mem_data_d;
  logic [NUM_WORDS-1:0]  mem_store_q, mem_store_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  grant_id;
  logic                  grant_valid;
  logic [NUM_WORDS-1:0]  word_hit;

  byte_memory_write_arbiter_rr_arbiter2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .prio        (ptr_q),
    .en          (state_q == ST_IDLE),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // An out-of-range address matches no word, so the decode is all-zero.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_hit
      assign word_hit[gi] = (addr_q == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Every output is the registered image of the state being entered.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    mem_data_d  = mem_data_q;
    mem_store_d = '0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d    = ST_SETUP;
          id_d       = grant_id;
          addr_d     = (grant_id == REQ1) ? addr1 : addr0;
          mem_data_d = (grant_id == REQ1) ? data1 : data0;
        end
      end
      ST_SETUP: begin
        state_d     = ST_STROBE;
        mem_store_d = word_hit;
      end
      ST_STROBE: begin
        state_d = ST_HOLD;
        ack0_d  = (id_q == REQ0);
        ack1_d  = (id_q == REQ1);
        err_d   = ~|word_hit;
        ptr_d   = other_req(id_q);
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      id_q        <= REQ0;
      ptr_q       <= REQ0;
      addr_q      <= '0;
      mem_data_q  <= '0;
      mem_store_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      mem_data_q  <= mem_data_d;
      mem_store_q <= mem_store_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign mem_data  = mem_data_q;
  assign mem_store = mem_store_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_memory_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_memory_write_arbiter
// Purpose  : checks two arbiter instances (4-word and 3-word banks) against a phase model
// Revision : 1.0  initial release
// ============================================================================
module tb_byte_memory_write_arbiter;

  localparam int BW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] data0, data1;

  logic          ack0_a, ack1_a, err_a, busy_a;
  logic [BW-1:0] md_a;
  logic [3:0]    st_a;
  logic          ack0_b, ack1_b, err_b, busy_b;
  logic [BW-1:0] md_b;
  logic [2:0]    st_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_memory_write_arbiter #(.BIT_COUNT(BW), .NUM_WORDS(4), .ADDR_WIDTH(AW)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0_a),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1_a),
    .mem_data(md_a), .mem_store(st_a), .err(err_a), .busy(busy_a)
  );

  byte_memory_write_arbiter #(.BIT_COUNT(BW), .NUM_WORDS(3), .ADDR_WIDTH(AW)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0_b),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1_b),
    .mem_data(md_b), .mem_store(st_b), .err(err_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a write is a 4-step phase count (0 idle, 1 setup, 2 strobe, 3 hold).
  logic [1:0]    m_phase;
  logic          m_ptr, m_id;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;
  logic [BW-1:0] exp_a [4];
  logic [BW-1:0] exp_b [3];
  logic [BW-1:0] lat_a [4];
  logic [BW-1:0] lat_b [3];
  bit            known_a [4];
  bit            known_b [3];

  function automatic logic pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1) return p;
    return r1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (m_phase == 2'd2) begin
        if (m_addr < 2'd3) known_b[m_addr] <= 1'b0;
        known_a[m_addr] <= 1'b0;
      end
      m_phase <= 2'd0;
      m_ptr   <= 1'b0;
      m_id    <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
    end else if (m_phase == 2'd0) begin
      if (req0 || req1) begin
        m_phase <= 2'd1;
        m_id    <= pick(req0, req1, m_ptr);
        m_addr  <= pick(req0, req1, m_ptr) ? addr1 : addr0;
        m_data  <= pick(req0, req1, m_ptr) ? data1 : data0;
      end
    end else begin
      if (m_phase == 2'd1) begin
        exp_a[m_addr]   <= m_data;
        known_a[m_addr] <= 1'b1;
        if (m_addr < 2'd3) begin
          exp_b[m_addr]   <= m_data;
          known_b[m_addr] <= 1'b1;
        end
      end
      if (m_phase == 2'd2) m_ptr <= ~m_id;
      m_phase <= m_phase + 2'd1;
    end
  end

  // Level-sensitive byte latches fed by the bus, as the real bank sees it.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (st_a[i]) lat_a[i] <= md_a;
    for (int i = 0; i < 3; i++) if (st_b[i]) lat_b[i] <= md_b;
  end

  logic [BW-1:0] prev_md_a, prev_md_b;

  always @(negedge clk) begin
    check("busy_a", 64'(busy_a), 64'(m_phase != 2'd0));
    check("busy_b", 64'(busy_b), 64'(m_phase != 2'd0));
    check("mem_data_a", 64'(md_a), 64'(m_data));
    check("mem_data_b", 64'(md_b), 64'(m_data));
    check("mem_store_a", 64'(st_a), 64'((m_phase == 2'd2) ? (4'b0001 << m_addr) : 4'b0000));
    check("mem_store_b", 64'(st_b),
          64'((m_phase == 2'd2 && m_addr < 2'd3) ? (3'b001 << m_addr) : 3'b000));
    check("ack0_a", 64'(ack0_a), 64'(m_phase == 2'd3 && m_id == 1'b0));
    check("ack1_a", 64'(ack1_a), 64'(m_phase == 2'd3 && m_id == 1'b1));
    check("ack0_b", 64'(ack0_b), 64'(m_phase == 2'd3 && m_id == 1'b0));
    check("ack1_b", 64'(ack1_b), 64'(m_phase == 2'd3 && m_id == 1'b1));
    check("err_a", 64'(err_a), 64'(0));
    check("err_b", 64'(err_b), 64'(m_phase == 2'd3 && m_addr >= 2'd3));
    if (|st_a) check("md_stable_a", 64'(md_a), 64'(prev_md_a));
    if (|st_b) check("md_stable_b", 64'(md_b), 64'(prev_md_b));
    prev_md_a <= md_a;
    prev_md_b <= md_b;
  end

  int got_order [$];
  int got_cyc   [$];

  task automatic wait_ack(input bit who, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((!who && ack0_a) || (who && ack1_a)) seen = 1'b1;
    end
    check(who ? "ack1_wait" : "ack0_wait", 64'(seen), 64'(1));
  endtask

  task automatic run_grants(input int n, input bit drop_on_ack, input int budget);
    got_order.delete();
    got_cyc.delete();
    for (int i = 0; i < budget && got_order.size() < n; i++) begin
      @(negedge clk);
      if (ack0_a) begin
        got_order.push_back(0);
        got_cyc.push_back(i);
        if (drop_on_ack) req0 = 1'b0;
      end
      if (ack1_a) begin
        got_order.push_back(1);
        got_cyc.push_back(i);
        if (drop_on_ack) req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("grant_count", 64'(got_order.size()), 64'(n));
  endtask

  task automatic rand_req(inout logic r, inout logic [AW-1:0] a, inout logic [BW-1:0] d,
                          input logic ack);
    if (r) begin
      if (ack) begin
        r = ($urandom_range(3) == 0);
        a = AW'($urandom);
        d = BW'($urandom);
      end else if ($urandom_range(3) == 0) begin
        d = BW'($urandom);
      end
    end else if ($urandom_range(2) == 0) begin
      r = 1'b1;
      a = AW'($urandom);
      d = BW'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_store", 64'(st_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    reset = 1'b0;

    // single write to word 1
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'hA5;
    wait_ack(1'b0, 8);
    req0 = 1'b0;
    check("word1", 64'(lat_a[1]), 64'(8'hA5));

    // data changes after capture must not reach the bus
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    @(negedge clk);
    data0 = 8'h00;
    wait_ack(1'b0, 8);
    req0 = 1'b0;
    check("word2", 64'(lat_a[2]), 64'(8'hA5));

    // reset in the middle of a strobe
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'h3C;
    repeat (2) @(negedge clk);
    check("pre_rst_store", 64'(st_a), 64'(4'b0100));
    #1 reset = 1'b1;
    req0 = 1'b0;
    #1;
    check("mid_rst_store", 64'(st_a), 64'(0));
    check("mid_rst_busy", 64'(busy_a), 64'(0));
    check("mid_rst_ack", 64'({ack0_a, ack1_a}), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // simultaneous requests right after reset: requester 0 first
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h22;
    run_grants(2, 1'b1, 20);
    if (got_order.size() == 2) begin
      check("simul_first", 64'(got_order[0]), 64'(0));
      check("simul_second", 64'(got_order[1]), 64'(1));
      check("simul_gap", 64'(got_cyc[1] - got_cyc[0]), 64'(4));
    end

    // continuous contention alternates
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h33;
    req1 = 1'b1; addr1 = 2'd2; data1 = 8'h44;
    run_grants(4, 1'b0, 30);
    for (int i = 0; i < got_order.size(); i++) begin
      check($sformatf("rr_order%0d", i), 64'(got_order[i]), 64'(i % 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'(4));
    end

    // address 3 is outside the 3-word bank
    @(negedge clk);
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h5A;
    wait_ack(1'b1, 8);
    check("oor_err_b", 64'(err_b), 64'(1));
    check("oor_ack1_b", 64'(ack1_b), 64'(1));
    req1 = 1'b0;

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rand_req(req0, addr0, data0, ack0_a);
      rand_req(req1, addr1, data1, ack1_a);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 4; i++)
      if (known_a[i]) check($sformatf("word_a%0d", i), 64'(lat_a[i]), 64'(exp_a[i]));
    for (int i = 0; i < 3; i++)
      if (known_b[i]) check($sformatf("word_b%0d", i), 64'(lat_b[i]), 64'(exp_b[i]));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
